// File: rtl/hsaf_pkg.sv
// Shared definitions for the HSAF MSE monitor: convergence states,
// accumulator sizing and the saturate-to-signed-max helper.
package hsaf_pkg;

    typedef enum logic {
        SEARCH    = 1'b0,
        CONVERGED = 1'b1
    } convState_e;

    // Wide enough for 2^log2Win squared samples of a width-bit signed value.
    function automatic int accWidth(input int width, input int log2Win);
        return 2 * width - 1 + log2Win;
    endfunction

    function automatic logic [63:0] satSignedMax(input logic [63:0] value, input int width);
        logic [63:0] maxVal;
        maxVal = (64'd1 << (width - 1)) - 64'd1;
        return (value > maxVal) ? maxVal : value;
    endfunction

endpackage

// File: rtl/hsaf_win_accum.sv
// Window accumulator: squares each accepted error sample, tags the last sample
// of the window and sums the squares; pulses done_o alongside the window sum.
module hsaf_win_accum
    import hsaf_pkg::*;
#(
    parameter int WIDTH    = 16,
    parameter int LOG2_WIN = 8,
    localparam int ACCW    = accWidth(WIDTH, LOG2_WIN)
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] error_i,
    output logic [ACCW-1:0]  winSum_o,
    output logic             done_o
);

    logic signed [2*WIDTH-1:0] square;
    logic [LOG2_WIN-1:0]       cnt_q, cnt_d;
    logic [2*WIDTH-2:0]        prod_q, prod_d;
    logic                      prodValid_q, prodValid_d;
    logic                      last_q, last_d;
    logic [ACCW-1:0]           acc_q, acc_d;
    logic [ACCW-1:0]           winSum;

    assign square   = $signed(error_i) * $signed(error_i);
    assign winSum   = acc_q + ACCW'(prod_q);
    assign winSum_o = winSum;
    assign done_o   = prodValid_q & last_q;

    // The top bit of a signed square is always zero, so 2*WIDTH-1 bits suffice.
    always_comb begin
        cnt_d       = cnt_q;
        prod_d      = prod_q;
        prodValid_d = 1'b0;
        last_d      = 1'b0;
        acc_d       = acc_q;
        if (clear_i) begin
            cnt_d = '0;
            acc_d = '0;
        end else begin
            if (en_i) begin
                prod_d      = (2*WIDTH-1)'(square);
                prodValid_d = 1'b1;
                last_d      = (cnt_q == '1);
                cnt_d       = cnt_q + LOG2_WIN'(1);
            end
            if (prodValid_q) begin
                acc_d = last_q ? '0 : winSum;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            cnt_q       <= '0;
            prod_q      <= '0;
            prodValid_q <= 1'b0;
            last_q      <= 1'b0;
            acc_q       <= '0;
        end else begin
            cnt_q       <= cnt_d;
            prod_q      <= prod_d;
            prodValid_q <= prodValid_d;
            last_q      <= last_d;
            acc_q       <= acc_d;
        end
    end

endmodule

// File: rtl/hsaf_mse_monitor.sv
// Block MSE monitor for the HSAF LMS error stream: rounds and saturates each
// window sum into a handshaked result and tracks convergence with hysteresis.
module hsaf_mse_monitor
    import hsaf_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               QP        = 12,
    parameter int               LOG2_WIN  = 8,
    parameter logic [WIDTH-1:0] THRESH    = 16'h0010,
    parameter int               HOLD_WINS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clear,
    input  logic [WIDTH-1:0] error,
    output logic [WIDTH-1:0] mse_out,
    output logic             mse_valid,
    input  logic             mse_ready,
    output logic             converged,
    output logic             overrun
);

    localparam int ACCW  = accWidth(WIDTH, LOG2_WIN);
    localparam int SHIFT = LOG2_WIN + QP;
    localparam int QCW   = $clog2(HOLD_WINS + 1);
    localparam logic [ACCW:0]  ROUND   = (ACCW+1)'(1) << (SHIFT - 1);
    localparam logic [WIDTH:0] THRESH2 = {THRESH, 1'b0};

    logic [ACCW-1:0]  winSum;
    logic             winDone;
    logic [ACCW:0]    roundedSum;
    logic [ACCW:0]    mRaw;
    logic [WIDTH-1:0] mseSat;
    logic [QCW-1:0]   quietInc;

    logic [WIDTH-1:0] mseOut_q, mseOut_d;
    logic             mseValid_q, mseValid_d;
    logic             overrun_q, overrun_d;
    convState_e       state_q, state_d;
    logic [QCW-1:0]   quiet_q, quiet_d;

    hsaf_win_accum #(
        .WIDTH    (WIDTH),
        .LOG2_WIN (LOG2_WIN)
    ) u_accum (
        .clk_i    (clk),
        .reset_i  (reset),
        .clear_i  (clear),
        .en_i     (en),
        .error_i  (error),
        .winSum_o (winSum),
        .done_o   (winDone)
    );

    // One spare bit keeps the rounding add from wrapping at full scale.
    assign roundedSum = {1'b0, winSum} + ROUND;
    assign mRaw       = roundedSum >> SHIFT;
    assign mseSat     = WIDTH'(satSignedMax(64'(mRaw), WIDTH));
    assign quietInc   = quiet_q + QCW'(1);

    always_comb begin
        mseOut_d   = mseOut_q;
        mseValid_d = mseValid_q;
        overrun_d  = overrun_q;
        state_d    = state_q;
        quiet_d    = quiet_q;
        if (clear) begin
            mseValid_d = 1'b0;
            state_d    = SEARCH;
            quiet_d    = '0;
        end else begin
            if (mseValid_q && mse_ready) begin
                mseValid_d = 1'b0;
            end
            if (winDone) begin
                mseOut_d   = mseSat;
                mseValid_d = 1'b1;
                if (mseValid_q && !mse_ready) begin
                    overrun_d = 1'b1;
                end
                // Leaving CONVERGED needs twice the entry threshold.
                case (state_q)
                    SEARCH: begin
                        if (mseSat <= THRESH) begin
                            if (quietInc >= QCW'(HOLD_WINS)) begin
                                state_d = CONVERGED;
                                quiet_d = '0;
                            end else begin
                                quiet_d = quietInc;
                            end
                        end else begin
                            quiet_d = '0;
                        end
                    end
                    CONVERGED: begin
                        if ({1'b0, mseSat} > THRESH2) begin
                            state_d = SEARCH;
                        end
                    end
                    default: state_d = SEARCH;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            mseOut_q   <= '0;
            mseValid_q <= 1'b0;
            overrun_q  <= 1'b0;
            state_q    <= SEARCH;
            quiet_q    <= '0;
        end else begin
            mseOut_q   <= mseOut_d;
            mseValid_q <= mseValid_d;
            overrun_q  <= overrun_d;
            state_q    <= state_d;
            quiet_q    <= quiet_d;
        end
    end

    assign mse_out   = mseOut_q;
    assign mse_valid = mseValid_q;
    assign overrun   = overrun_q;
    assign converged = (state_q == CONVERGED);

endmodule

// File: tb/tb_hsaf_mse_monitor.sv
// Directed bench for hsaf_mse_monitor with a 4-sample window and HOLD_WINS=2;
// expected values are hand-computed from the round/saturate formula.
module tb_hsaf_mse_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic        clear;
    logic [15:0] error;
    logic [15:0] mse_out;
    logic        mse_valid;
    logic        mse_ready;
    logic        converged;
    logic        overrun;

    int checks   = 0;
    int failures = 0;

    hsaf_mse_monitor #(
        .WIDTH     (16),
        .QP        (12),
        .LOG2_WIN  (2),
        .THRESH    (16'h0010),
        .HOLD_WINS (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .clear     (clear),
        .error     (error),
        .mse_out   (mse_out),
        .mse_valid (mse_valid),
        .mse_ready (mse_ready),
        .converged (converged),
        .overrun   (overrun)
    );

    always #5 clk = ~clk;

    task automatic applyStimulus(input logic enV, input logic [15:0] errV,
                                 input logic clrV, input logic rdyV);
        en        = enV;
        error     = errV;
        clear     = clrV;
        mse_ready = rdyV;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Four enabled samples, then one idle edge on which the result loads.
    task automatic sendWindow(input logic [15:0] errV, input logic rdyV);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, errV, 1'b0, rdyV);
        applyStimulus(1'b0, 16'h0000, 1'b0, rdyV);
    endtask

    initial begin
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("reset_mse_out", mse_out, 16'h0000);
        checkOutput("reset_valid", {15'b0, mse_valid}, 16'h0000);
        checkOutput("reset_converged", {15'b0, converged}, 16'h0000);
        checkOutput("reset_overrun", {15'b0, overrun}, 16'h0000);
        reset = 1'b1;

        sendWindow(16'h1000, 1'b1);
        checkOutput("w1000_mse", mse_out, 16'h1000);
        checkOutput("w1000_valid", {15'b0, mse_valid}, 16'h0001);
        sendWindow(16'h0800, 1'b1);
        checkOutput("w0800_mse", mse_out, 16'h0400);
        sendWindow(16'h8000, 1'b1);
        checkOutput("w8000_sat", mse_out, 16'h7FFF);
        checkOutput("w8000_overrun", {15'b0, overrun}, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("accept_drop_valid", {15'b0, mse_valid}, 16'h0000);

        sendWindow(16'h0040, 1'b1);
        checkOutput("quiet1_mse", mse_out, 16'h0001);
        checkOutput("quiet1_conv", {15'b0, converged}, 16'h0000);
        sendWindow(16'h0040, 1'b1);
        checkOutput("quiet2_mse", mse_out, 16'h0001);
        checkOutput("quiet2_conv", {15'b0, converged}, 16'h0001);
        sendWindow(16'h0139, 1'b1);
        checkOutput("hyst_mse", mse_out, 16'h0018);
        checkOutput("hyst_conv", {15'b0, converged}, 16'h0001);
        sendWindow(16'h0018, 1'b1);
        checkOutput("small_mse", mse_out, 16'h0000);
        checkOutput("small_conv", {15'b0, converged}, 16'h0001);
        sendWindow(16'h1000, 1'b1);
        checkOutput("loud_conv", {15'b0, converged}, 16'h0000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

        sendWindow(16'h1000, 1'b0);
        checkOutput("stall1_valid", {15'b0, mse_valid}, 16'h0001);
        checkOutput("stall1_overrun", {15'b0, overrun}, 16'h0000);
        sendWindow(16'h0800, 1'b0);
        checkOutput("stall2_mse", mse_out, 16'h0400);
        checkOutput("stall2_valid", {15'b0, mse_valid}, 16'h0001);
        checkOutput("stall2_overrun", {15'b0, overrun}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("stall_accept_valid", {15'b0, mse_valid}, 16'h0000);
        checkOutput("stall_accept_overrun", {15'b0, overrun}, 16'h0001);

        for (int i = 0; i < 6; i++) applyStimulus((i % 2) == 0, 16'h1000, 1'b0, 1'b1);
        checkOutput("gap_no_early_result", {15'b0, mse_valid}, 16'h0000);
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h1000, 1'b0, 1'b1);
        checkOutput("gap_valid", {15'b0, mse_valid}, 16'h0001);
        checkOutput("gap_mse", mse_out, 16'h1000);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);

        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b1);
        reset = 1'b0;
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        reset = 1'b1;
        checkOutput("midreset_mse", mse_out, 16'h0000);
        checkOutput("midreset_overrun", {15'b0, overrun}, 16'h0000);
        sendWindow(16'h0800, 1'b1);
        checkOutput("midreset_result", mse_out, 16'h0400);
        checkOutput("midreset_valid", {15'b0, mse_valid}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("midreset_single", {15'b0, mse_valid}, 16'h0000);

        sendWindow(16'h1000, 1'b0);
        sendWindow(16'h1000, 1'b0);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("preclear_overrun", {15'b0, overrun}, 16'h0001);
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1000, 1'b0, 1'b1);
        applyStimulus(1'b1, 16'h1000, 1'b1, 1'b1);
        checkOutput("clear_keeps_mse", mse_out, 16'h1000);
        checkOutput("clear_valid", {15'b0, mse_valid}, 16'h0000);
        sendWindow(16'h0800, 1'b1);
        checkOutput("postclear_mse", mse_out, 16'h0400);
        checkOutput("postclear_valid", {15'b0, mse_valid}, 16'h0001);
        checkOutput("postclear_overrun", {15'b0, overrun}, 16'h0001);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        applyStimulus(1'b0, 16'h0000, 1'b0, 1'b1);
        checkOutput("postclear_single", {15'b0, mse_valid}, 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
